imm_pack: RTL
=============

// Module: imm_pack
// PURPOSE
//  Inverse of the decode-side immediate generator. Takes a 32-bit immediate
//  value, a format selector and a base instruction word. Inserts the immediate
//  into the RISC-V RV32 I/S/B/U/J bit fields and emits the encoded word.
//  Sits on the instruction-producer side: boot-ROM patcher, trampoline builder,
//  self-test stimulus generator. Valid/ready on both sides, 2-entry skid
//  buffering, range/alignment checking and a saturating error counter.
// PARAMETERS
//  ERR_CNT_W  8  width of the saturating error counter err_cnt_o
// PORTS
//  clk_i        in   1   clock
//  rst_ni       in   1   reset, asynchronous assert, active low
//  in_valid_i   in   1   request valid
//  in_ready_o   out  1   request accepted when in_valid_i && in_ready_o
//  base_i       in   32  types::word_t; supplies all non-immediate fields
//  imm_i        in   32  types::word_t; immediate as signed/absolute value
//  type_i       in   -   types::imm_t; i_type/s_type/b_type/u_type/j_type
//  out_valid_o  out  1   encoded word valid
//  out_ready_i  in   1   consumer ready
//  instr_o      out  32  types::word_t; encoded instruction
//  err_o        out  1   qualifies instr_o: immediate unrepresentable
//  err_cnt_o    out  ERR_CNT_W  accepted requests with error, saturating
// BEHAVIOUR
//  Reset: in_ready_o=1, out_valid_o=0, instr_o=0, err_o=0, err_cnt_o=0.
//    Both skid entries are invalid after reset.
//  Pack rule: start from base_i. Clear all immediate bit positions of the
//    selected format. OR in the immediate bits:
//   I: [31:20]=imm[11:0]
//   S: [31:25]=imm[11:5], [11:7]=imm[4:0]
//   B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
//   U: [31:12]=imm[31:12]
//   J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
//  Error rules (err=1). The encoded word is still produced from the
//  truncated bits:
//   I,S: imm[31:11] not all equal
//   B: imm[31:12] not all equal, or imm[0]=1
//   J: imm[31:20] not all equal, or imm[0]=1
//   U: imm[11:0] != 0
//   Any other type_i encoding: err=1, instr=base_i unchanged
//  Latency: one cycle from acceptance to out_valid_o when out_ready_i=1.
//  Buffering: main register plus skid register (2 entries).
//   - in_ready_o is registered: it is 1 iff the skid entry is empty.
//   - Accept with the main register full and out_ready_i=0: the request goes
//     to the skid register and in_ready_o drops next cycle.
//   - Output pops while skid is full: the skid moves to main, in_ready_o
//     rises next cycle.
//   - Accept and pop in the same cycle: the new word goes to main; no stall.
//   - Strict FIFO order, no drops, no duplicates.
//   - instr_o/err_o are held stable while out_valid_o && !out_ready_i.
//  err_cnt_o increments on acceptance (not output) of an erroring request.
//    It holds at 2^ERR_CNT_W-1.
//  Reset mid-operation: both entries are discarded and outputs return to
//    reset values asynchronously. No partial word is emitted afterwards.
// STRUCTURE
//  types package: reuse word_t and imm_t. Add typedef imm_pack_req_t
//    {word_t base; word_t imm; imm_t kind} and localparams for per-format
//    field masks (IMM_MASK_I etc.).
//  Sub-module skid_buffer #(type T): a generic 2-entry valid/ready register
//    slice, reusable elsewhere. imm_pack = combinational pack/check function
//    + skid_buffer of {word_t, err} + counter.
// TESTING
//  1 I: base=0x00000013, imm=0xFFFFFFFF -> instr_o=0xFFF00013, err_o=0.
//    I: imm=0x00000800 -> err_o=1, instr_o=0x80000013, err_cnt_o 0->1.
//  2 S: base=0x00002023, imm=8 -> 0x00002423.
//    B: base=0x00000063, imm=0xFFFFFFFC -> 0xFE000EE3.
//    B: imm=3 -> err_o=1.
//  3 U: base=0x00000037, imm=0x12345000 -> 0x12345037.
//    U: imm=0x12345001 -> err_o=1.
//    J: base=0x0000006F, imm=0x800 -> 0x0010006F.
//  4 Backpressure: out_ready_i=0, offer 3 back-to-back -> 2 accepted,
//    in_ready_o=0 from the 3rd cycle. Release -> 3 words in order,
//    instr_o stable while stalled.
//  5 Full throughput: in_valid_i=out_ready_i=1 for 16 cycles -> 16 words,
//    one per cycle, in_ready_o never deasserts.
//  6 Saturation/reset: with ERR_CNT_W=2, 5 erroring requests -> err_cnt_o=3.
//    Assert rst_ni low with 2 words buffered -> out_valid_o=0 immediately,
//    err_cnt_o=0, no words after release.

Source files
------------

// File: rtl/imm_pack_pkg.sv
// Shared types and field masks for the RV32 immediate packer.
package imm_pack_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    I_TYPE = 3'd0,
    S_TYPE = 3'd1,
    B_TYPE = 3'd2,
    U_TYPE = 3'd3,
    J_TYPE = 3'd4
  } imm_t;

  typedef struct packed {
    word_t base;
    word_t imm;
    imm_t  kind;
  } imm_pack_req_t;

  typedef struct packed {
    word_t instr;
    logic  err;
  } imm_pack_rsp_t;

  // Instruction bit positions owned by the immediate in each format
  localparam word_t IMM_MASK_I = 32'hFFF0_0000;
  localparam word_t IMM_MASK_S = 32'hFE00_0F80;
  localparam word_t IMM_MASK_B = 32'hFE00_0F80;
  localparam word_t IMM_MASK_U = 32'hFFFF_F000;
  localparam word_t IMM_MASK_J = 32'hFFFF_F000;

endpackage

// File: rtl/imm_pack_skid_buffer.sv
// Generic 2-entry valid/ready register slice: output (main) register plus skid.
module skid_buffer #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  T     main_q, main_d, skid_q, skid_d;
  logic push, pop;

  assign in_ready_o  = ~skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_data_o  = main_q;
  assign push        = in_valid_i & ~skid_v_q;
  assign pop         = main_v_q & out_ready_i;

  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    // Pop is resolved first so a same-cycle push lands in main when it frees up
    if (pop) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = 1'b0;
      end
    end
    if (push) begin
      if (!main_v_d) begin
        main_v_d = 1'b1;
        main_d   = in_data_i;
      end else begin
        skid_v_d = 1'b1;
        skid_d   = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

endmodule

// File: rtl/imm_pack.sv
// Packs an immediate into the I/S/B/U/J fields of a base RV32 instruction word.
module imm_pack
  import imm_pack_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  word_t                base_i,
  input  word_t                imm_i,
  input  imm_t                 type_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output word_t                instr_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  imm_pack_req_t        req;
  imm_pack_rsp_t        rsp, rsp_out;
  logic                 accept;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign req = '{base: base_i, imm: imm_i, kind: type_i};

  always_comb begin
    rsp.instr = req.base;
    rsp.err   = 1'b1;
    case (req.kind)
      I_TYPE: begin
        rsp.instr = (req.base & ~IMM_MASK_I) | {req.imm[11:0], 20'b0};
        rsp.err   = ~(&req.imm[31:11] | ~|req.imm[31:11]);
      end
      S_TYPE: begin
        rsp.instr = (req.base & ~IMM_MASK_S)
                  | {req.imm[11:5], 13'b0, req.imm[4:0], 7'b0};
        rsp.err   = ~(&req.imm[31:11] | ~|req.imm[31:11]);
      end
      B_TYPE: begin
        rsp.instr = (req.base & ~IMM_MASK_B)
                  | {req.imm[12], req.imm[10:5], 13'b0, req.imm[4:1], req.imm[11], 7'b0};
        rsp.err   = ~(&req.imm[31:12] | ~|req.imm[31:12]) | req.imm[0];
      end
      U_TYPE: begin
        rsp.instr = (req.base & ~IMM_MASK_U) | {req.imm[31:12], 12'b0};
        rsp.err   = |req.imm[11:0];
      end
      J_TYPE: begin
        rsp.instr = (req.base & ~IMM_MASK_J)
                  | {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], 12'b0};
        rsp.err   = ~(&req.imm[31:20] | ~|req.imm[31:20]) | req.imm[0];
      end
      default: begin
        rsp.instr = req.base;
        rsp.err   = 1'b1;
      end
    endcase
  end

  skid_buffer #(.T(imm_pack_rsp_t)) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (rsp),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (rsp_out)
  );

  assign instr_o = rsp_out.instr;
  assign err_o   = rsp_out.err;
  assign accept  = in_valid_i & in_ready_o;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && rsp.err && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;

endmodule
